tag_free_list: RTL and testbench

- Circular free list of physical register tags for the rename stage.
- Hands out unused 5-bit tags to rename (allocate/read side) and accepts tags back from commit (release/write side).
- Sits between rename and the reorder-buffer retire logic.
- softReset is the pipeline-flush path and re-initialises the list exactly like reset.

---
 rtl/tag_free_list_pkg.sv | 19 +
 rtl/tag_free_list_wrap_ptr.sv | 23 ++
 rtl/tag_free_list.sv | 76 +++++++
 tb/tb_tag_free_list.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tag_free_list_pkg.sv
// Shared constants and types for the rename-stage physical tag free list.
package tag_free_list_pkg;

  localparam int unsigned TAG_W    = 5;
  localparam int unsigned NUM_TAGS = 32;
  localparam int unsigned RESERVED = 8;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   tag_cnt_t;

  localparam tag_t     TAIL_INIT  = tag_t'((NUM_TAGS - RESERVED) % NUM_TAGS);
  localparam tag_cnt_t COUNT_INIT = tag_cnt_t'(NUM_TAGS - RESERVED);

  function automatic tag_t init_entry(input int unsigned idx);
    if (idx < NUM_TAGS - RESERVED) return tag_t'(RESERVED + idx);
    return '0;
  endfunction

endpackage

// File: rtl/tag_free_list_wrap_ptr.sv
// Modulo-NUM_TAGS pointer register with increment enable and reset-load value.
module wrap_ptr
  import tag_free_list_pkg::*;
#(
  parameter tag_t LOAD = '0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_inc,
  output tag_t o_ptr
);

  tag_t r_ptr;

  // NUM_TAGS == 2**TAG_W, so natural overflow of the TAG_W-bit add is the wrap.
  always_ff @(posedge clk) begin
    if (i_rst)      r_ptr <= LOAD;
    else if (i_inc) r_ptr <= r_ptr + tag_t'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/tag_free_list.sv
// Circular free list of physical register tags: rename pops at head, commit pushes at tail.
module tag_free_list
  import tag_free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 softReset,
  input  logic                 allocReq,
  output logic                 allocValid,
  output logic [TAG_W-1:0]     allocTag,
  input  logic                 freeEn,
  input  logic [TAG_W-1:0]     freeTag,
  output logic [TAG_W:0]       count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflowErr
);

  tag_t     r_entry [NUM_TAGS];
  tag_cnt_t r_count;
  logic     r_overflow;

  logic     w_rst;
  logic     w_pop;
  logic     w_push;
  logic     w_empty;
  logic     w_full;
  tag_t     w_head;
  tag_t     w_tail;

  assign w_rst   = reset | softReset;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == tag_cnt_t'(NUM_TAGS));
  assign w_pop   = allocReq & ~w_empty;
  // A same-cycle pop frees a slot, so a push into a full list is still accepted.
  assign w_push  = freeEn & (~w_full | w_pop);

  wrap_ptr #(.LOAD('0)) u_head (
    .clk   (clk),
    .i_rst (w_rst),
    .i_inc (w_pop),
    .o_ptr (w_head)
  );

  wrap_ptr #(.LOAD(TAIL_INIT)) u_tail (
    .clk   (clk),
    .i_rst (w_rst),
    .i_inc (w_push),
    .o_ptr (w_tail)
  );

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (w_rst)                             r_entry[i] <= init_entry(i);
      else if (w_push && w_tail == tag_t'(i)) r_entry[i] <= freeTag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_count    <= COUNT_INIT;
      r_overflow <= 1'b0;
    end else begin
      r_count <= r_count + tag_cnt_t'(w_push) - tag_cnt_t'(w_pop);
      if (freeEn && !w_push) r_overflow <= 1'b1;
    end
  end

  assign allocValid  = ~w_empty;
  assign allocTag    = r_entry[w_head];
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign overflowErr = r_overflow;

endmodule

// File: tb/tb_tag_free_list.sv
// Directed self-checking bench for tag_free_list.
module tb_tag_free_list;

  logic       clk = 1'b0;
  logic       reset, softReset, allocReq, freeEn;
  logic [4:0] freeTag;
  logic       allocValid, empty, full, overflowErr;
  logic [4:0] allocTag;
  logic [5:0] count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  tag_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .softReset   (softReset),
    .allocReq    (allocReq),
    .allocValid  (allocValid),
    .allocTag    (allocTag),
    .freeEn      (freeEn),
    .freeTag     (freeTag),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflowErr (overflowErr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(allocValid), 1);
    chk({tag, "_tag"},   32'(allocTag), 8);
    chk({tag, "_count"}, 32'(count), 24);
    chk({tag, "_empty"}, 32'(empty), 0);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_ovf"},   32'(overflowErr), 0);
  endtask

  initial begin
    reset = 1'b1; softReset = 1'b0; allocReq = 1'b0; freeEn = 1'b0; freeTag = '0;
    step();
    reset = 1'b0;
    step();
    step();
    chk_reset_state("reset");

    // Drain all 24 free tags
    allocReq = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("drain_tag%0d", i), 32'(allocTag), 32'(8 + i));
      step();
    end
    chk("drained_count", 32'(count), 0);
    chk("drained_empty", 32'(empty), 1);
    chk("drained_valid", 32'(allocValid), 0);
    step();
    chk("underflow_count", 32'(count), 0);
    chk("underflow_valid", 32'(allocValid), 0);

    // Free into empty list with simultaneous allocReq: no bypass
    freeEn = 1'b1; freeTag = 5'd5;
    chk("nobypass_valid", 32'(allocValid), 0);
    step();
    freeEn = 1'b0; allocReq = 1'b0;
    chk("refill_valid", 32'(allocValid), 1);
    chk("refill_tag",   32'(allocTag), 5);
    chk("refill_count", 32'(count), 1);

    // Fill to full from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    freeEn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      freeTag = 5'(t);
      step();
    end
    chk("fill_count", 32'(count), 32);
    chk("fill_full",  32'(full), 1);
    chk("fill_tag",   32'(allocTag), 8);

    // Full with push and pop together: push accepted into wrapped tail (entry 0)
    freeTag = 5'd3; allocReq = 1'b1;
    step();
    allocReq = 1'b0; freeEn = 1'b0;
    chk("fullpp_count", 32'(count), 32);
    chk("fullpp_ovf",   32'(overflowErr), 0);
    chk("fullpp_tag",   32'(allocTag), 9);

    // Overflow: free while full, no pop
    freeEn = 1'b1; freeTag = 5'd12;
    step();
    freeEn = 1'b0;
    chk("ovf_count", 32'(count), 32);
    chk("ovf_set",   32'(overflowErr), 1);
    for (int i = 0; i < 5; i++) step();
    chk("ovf_sticky", 32'(overflowErr), 1);

    // Walk head from entry 1 round to entry 0
    allocReq = 1'b1;
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("walk_tag%0d", k), 32'(allocTag), (k < 24) ? 32'(k + 8) : 32'(k - 24));
      step();
    end
    allocReq = 1'b0;
    chk("wrap_entry0_tag", 32'(allocTag), 3);
    chk("wrap_count",      32'(count), 1);
    chk("wrap_ovf",        32'(overflowErr), 1);

    // softReset alone clears sticky error and restores list
    softReset = 1'b1;
    step();
    softReset = 1'b0;
    chk_reset_state("soft1");

    allocReq = 1'b1;
    for (int i = 0; i < 10; i++) step();
    allocReq = 1'b0;
    freeEn = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      freeTag = 5'(t);
      step();
    end
    freeEn = 1'b0;
    chk("mid_count", 32'(count), 17);
    chk("mid_tag",   32'(allocTag), 18);

    // softReset discards same-cycle pop and push
    softReset = 1'b1; allocReq = 1'b1; freeEn = 1'b1; freeTag = 5'd20;
    step();
    softReset = 1'b0; allocReq = 1'b0; freeEn = 1'b0;
    chk_reset_state("soft2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
